// File: rtl/fpdiv_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// fpdiv_ctrl_if : start/status handshake and fpdiv select/load bundle
// Revision 1.0
//==============================================================================
interface fpdiv_ctrl_if;
   logic       start;
   logic [1:0] sel_muxa;
   logic [1:0] sel_muxb;
   logic       load_rega;
   logic       load_regb;
   logic       load_regc;
   logic       busy;
   logic       done;

   modport master (
      output start,
      input  sel_muxa, sel_muxb, load_rega, load_regb, load_regc, busy, done
   );

   modport slave (
      input  start,
      output sel_muxa, sel_muxb, load_rega, load_regb, load_regc, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/fpdiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// fpdiv_ctrl : sequencing FSM for the Goldschmidt mantissa divider datapath
// Revision 1.0
//==============================================================================
module fpdiv_ctrl #(
   parameter int ITER = 3
) (
   input  wire logic   clk,
   input  wire logic   reset,
   fpdiv_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_D0   = 3'd1,
      S_N0   = 3'd2,
      S_NI   = 3'd3,
      S_DI   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [3:0] c_iter = 4'(ITER);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_next;

   logic [1:0] w_sel_a;
   logic [1:0] w_sel_b;
   logic       w_ld_a;
   logic       w_ld_b;
   logic       w_ld_c;
   logic       w_busy;
   logic       w_done;

   logic [1:0] r_sel_a;
   logic [1:0] r_sel_b;
   logic       r_ld_a;
   logic       r_ld_b;
   logic       r_ld_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_sel_a    = 2'd0;
      w_sel_b    = 2'd0;
      w_ld_a     = 1'b0;
      w_ld_b     = 1'b0;
      w_ld_c     = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_D0;
         end
         S_D0: begin
            w_sel_a = 2'd2;
            w_sel_b = 2'd0;
            w_ld_a  = 1'b1;
            w_ld_c  = 1'b1;
            w_busy  = 1'b1;
            w_next  = S_N0;
         end
         S_N0: begin
            w_sel_a    = 2'd2;
            w_sel_b    = 2'd1;
            w_ld_b     = 1'b1;
            w_busy     = 1'b1;
            w_cnt_next = 4'd1;
            w_next     = S_NI;
         end
         S_NI: begin
            // Last numerator step goes straight to DONE; the trailing
            // denominator update would be wasted work.
            w_sel_a = 2'd0;
            w_sel_b = 2'd2;
            w_ld_b  = 1'b1;
            w_busy  = 1'b1;
            w_next  = (r_cnt >= c_iter) ? S_DONE : S_DI;
         end
         S_DI: begin
            w_sel_a = 2'd0;
            w_sel_b = 2'd3;
            w_ld_a  = 1'b1;
            w_ld_c  = 1'b1;
            w_busy  = 1'b1;
            if (r_cnt < c_iter) w_cnt_next = r_cnt + 4'd1;
            w_next  = S_NI;
         end
         S_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Loads/selects settle on the falling edge so load&clk sees a clean high phase.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_sel_a <= 2'd0;
         r_sel_b <= 2'd0;
         r_ld_a  <= 1'b0;
         r_ld_b  <= 1'b0;
         r_ld_c  <= 1'b0;
      end else begin
         r_sel_a <= w_sel_a;
         r_sel_b <= w_sel_b;
         r_ld_a  <= w_ld_a;
         r_ld_b  <= w_ld_b;
         r_ld_c  <= w_ld_c;
      end
   end

   assign bus.sel_muxa  = r_sel_a;
   assign bus.sel_muxb  = r_sel_b;
   assign bus.load_rega = r_ld_a;
   assign bus.load_regb = r_ld_b;
   assign bus.load_regc = r_ld_c;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_fpdiv_ctrl : directed bench for fpdiv_ctrl (ITER=3 and ITER=1 builds)
// Revision 1.0
//==============================================================================
module tb_fpdiv_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fpdiv_ctrl_if if3();
   fpdiv_ctrl_if if1();

   fpdiv_ctrl #(.ITER(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
   fpdiv_ctrl #(.ITER(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   always #5 clk = ~clk;

   // {busy, done, sel_muxa, sel_muxb, load_rega, load_regb, load_regc}
   localparam logic [8:0] V_IDLE = 9'b0_0_00_00_000;
   localparam logic [8:0] V_D0   = 9'b1_0_10_00_101;
   localparam logic [8:0] V_N0   = 9'b1_0_10_01_010;
   localparam logic [8:0] V_NI   = 9'b1_0_00_10_010;
   localparam logic [8:0] V_DI   = 9'b1_0_00_11_101;
   localparam logic [8:0] V_DONE = 9'b1_1_00_00_000;

   function automatic logic [8:0] obs(input int which);
      if (which == 1)
         return {if1.busy, if1.done, if1.sel_muxa, if1.sel_muxb,
                 if1.load_rega, if1.load_regb, if1.load_regc};
      return {if3.busy, if3.done, if3.sel_muxa, if3.sel_muxb,
              if3.load_rega, if3.load_regb, if3.load_regc};
   endfunction

   // Expected vector k cycles after start was sampled.
   function automatic logic [8:0] exp_at(input int iter, input int k);
      if (k < 0) return V_IDLE;
      if (k == 0) return V_D0;
      if (k == 1) return V_N0;
      if (k <= 2*iter) return ((k % 2) == 0) ? V_NI : V_DI;
      if (k == 2*iter + 1) return V_DONE;
      return V_IDLE;
   endfunction

   task automatic set_start(input int which, input logic v);
      if (which == 1) if1.start = v;
      else            if3.start = v;
   endtask

   task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, o, e);
      end
   endtask

   task automatic check_int(input string tag, input int o, input int e);
      checks++;
      assert (o == e) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   // Runs one divide from IDLE. Posedge+1 sample: new busy/done with previous
   // loads still held; negedge+1 sample: full new vector.
   task automatic do_divide(input int which, input int iter, input string tag,
                            input bit hold, input int poke_lo, input int poke_hi);
      int na = 0;
      int nb = 0;
      int nc = 0;
      logic [8:0] e;
      logic [8:0] ep;
      logic [8:0] o;
      set_start(which, 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k <= 2*iter + 2; k++) begin
         set_start(which, hold || (k >= poke_lo && k <= poke_hi));
         e  = exp_at(iter, k);
         ep = exp_at(iter, k - 1);
         check($sformatf("%s k%0d pos", tag, k), obs(which), {e[8:7], ep[6:0]});
         @(negedge clk); #1;
         o = obs(which);
         check($sformatf("%s k%0d neg", tag, k), o, e);
         na += int'(o[2]);
         nb += int'(o[1]);
         nc += int'(o[0]);
         if (k != 2*iter + 2) begin
            @(posedge clk); #1;
         end
      end
      check_int({tag, " rega pulses"}, na, iter);
      check_int({tag, " regb pulses"}, nb, iter + 1);
      check_int({tag, " regc pulses"}, nc, iter);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] e;
      logic [8:0] ep;
      reset     = 1'b0;
      if3.start = 1'b0;
      if1.start = 1'b0;

      // Reset held with start toggling
      @(posedge clk); #1;
      check("rst hold a3", obs(0), V_IDLE);
      check("rst hold a1", obs(1), V_IDLE);
      set_start(0, 1'b1); set_start(1, 1'b1);
      @(negedge clk); #1;
      check("rst hold b3", obs(0), V_IDLE);
      @(posedge clk); #1;
      check("rst hold c3", obs(0), V_IDLE);
      check("rst hold c1", obs(1), V_IDLE);
      set_start(0, 1'b0); set_start(1, 1'b0);
      @(negedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("post rst a3", obs(0), V_IDLE);
      @(negedge clk); #1;
      check("post rst b3", obs(0), V_IDLE);
      check("post rst b1", obs(1), V_IDLE);

      // Single divide, stray start mid-flight must be ignored
      do_divide(0, 3, "div3", 1'b0, 3, 3);

      // Start held high: divides repeat every 9 cycles
      do_divide(0, 3, "bb0", 1'b1, -1, -2);
      do_divide(0, 3, "bb1", 1'b1, -1, -2);
      do_divide(0, 3, "bb2", 1'b1, -1, -2);

      // Abort with reset four cycles into a divide
      set_start(0, 1'b1);
      @(posedge clk); #1;
      set_start(0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         e  = exp_at(3, k);
         ep = exp_at(3, k - 1);
         check($sformatf("abort k%0d pos", k), obs(0), {e[8:7], ep[6:0]});
         @(negedge clk); #1;
         check($sformatf("abort k%0d neg", k), obs(0), e);
         @(posedge clk); #1;
      end
      check("abort k4 pos", obs(0), {V_NI[8:7], V_DI[6:0]});
      #1 reset = 1'b0;
      #1;
      check("abort async", obs(0), V_IDLE);
      @(negedge clk); #1;
      check("abort held neg", obs(0), V_IDLE);
      @(posedge clk); #1;
      check("abort held pos", obs(0), V_IDLE);
      @(negedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort released", obs(0), V_IDLE);
      @(negedge clk); #1;
      do_divide(0, 3, "after abort", 1'b0, -1, -2);

      // ITER=1 build, starts at t+1 and t+2 ignored
      do_divide(1, 1, "iter1", 1'b0, 0, 1);
      @(posedge clk); #1;
      check("iter1 idle", obs(1), V_IDLE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
